// File: rtl/jk_ff_driver_if.sv
// rtl/jk_ff_driver_if.sv - target-bit stream between a sequencer and jk_ff_driver
interface jk_ff_driver_if;
  logic d_in;
  logic d_valid;
  logic d_ready;

  // Sequencer side: offers target bits
  modport master (output d_in, output d_valid, input d_ready);
  // Driver side: accepts target bits
  modport slave (input d_in, input d_valid, output d_ready);
endinterface

// File: rtl/jk_ff_driver.sv
// rtl/jk_ff_driver.sv - JK flip-flop stimulus driver with excitation, pulse timing and readback check
module jk_ff_driver #(
  parameter int SETUP_W   = 2,
  parameter int PULSE_W   = 2,
  parameter bit TOGGLE_EN = 1'b0,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst,
  jk_ff_driver_if.slave    din,
  input  logic             qn,
  input  logic             qnf,
  output logic             j,
  output logic             k,
  output logic             fclk,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic             cur_q
);

  localparam int MAX_W = (SETUP_W > PULSE_W) ? SETUP_W : PULSE_W;
  localparam int CW    = $clog2(MAX_W + 1);

  typedef enum logic [2:0] {
    INIT_SETUP,
    SETUP,
    PULSE,
    HOLD,
    CHECK,
    IDLE
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             tgt, tgt_n;
  logic             rdy, rdy_n;
  logic             j_n, k_n, fclk_n, done_n;
  logic             err_n, cur_q_n;
  logic [CNT_W-1:0] err_cnt_n;
  logic             mismatch;

  assign din.d_ready = rdy;

  // State and all outputs are registered so FCLK, J and K never glitch
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= INIT_SETUP;
      cnt     <= '0;
      tgt     <= 1'b0;
      rdy     <= 1'b0;
      j       <= 1'b0;
      k       <= 1'b0;
      fclk    <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
      err_cnt <= '0;
      cur_q   <= 1'b0;
    end else begin
      state   <= state_n;
      cnt     <= cnt_n;
      tgt     <= tgt_n;
      rdy     <= rdy_n;
      j       <= j_n;
      k       <= k_n;
      fclk    <= fclk_n;
      done    <= done_n;
      err     <= err_n;
      err_cnt <= err_cnt_n;
      cur_q   <= cur_q_n;
    end
  end

  // Next-state, excitation, pulse timing and readback check
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    tgt_n     = tgt;
    rdy_n     = 1'b0;
    j_n       = j;
    k_n       = k;
    fclk_n    = 1'b0;
    done_n    = 1'b0;
    err_n     = err;
    err_cnt_n = err_cnt;
    cur_q_n   = cur_q;
    mismatch  = (qn != tgt) || (qnf == qn);

    case (state)
      // Reset leaves cnt at 0, so the first cycle out of reset (J=K=0)
      // is spent loading the clear excitation; K then has a full
      // SETUP_W cycles of setup before FCLK rises.
      INIT_SETUP: begin
        tgt_n = 1'b0;
        j_n   = 1'b0;
        k_n   = 1'b1;
        if (cnt == CW'(SETUP_W)) begin
          state_n = PULSE;
          cnt_n   = CW'(1);
          fclk_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      SETUP: begin
        if (cnt == CW'(SETUP_W)) begin
          state_n = PULSE;
          cnt_n   = CW'(1);
          fclk_n  = 1'b1;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end

      PULSE: begin
        if (cnt == CW'(PULSE_W)) begin
          state_n = HOLD;
        end else begin
          cnt_n  = cnt + 1'b1;
          fclk_n = 1'b1;
        end
      end

      HOLD: begin
        state_n = CHECK;
        done_n  = 1'b1;
      end

      // Resync the model to the real flop whether or not it matched
      CHECK: begin
        if (mismatch) begin
          err_n = 1'b1;
          if (err_cnt != {CNT_W{1'b1}}) begin
            err_cnt_n = err_cnt + 1'b1;
          end
        end
        cur_q_n = qn;
        j_n     = 1'b0;
        k_n     = 1'b0;
        rdy_n   = 1'b1;
        state_n = IDLE;
      end

      IDLE: begin
        if (din.d_valid && rdy) begin
          tgt_n   = din.d_in;
          state_n = SETUP;
          cnt_n   = CW'(1);
          if (cur_q == din.d_in) begin
            j_n = 1'b0;
            k_n = 1'b0;
          end else if (TOGGLE_EN) begin
            j_n = 1'b1;
            k_n = 1'b1;
          end else begin
            j_n = din.d_in;
            k_n = ~din.d_in;
          end
        end else begin
          rdy_n = 1'b1;
        end
      end

      default: begin
        state_n = INIT_SETUP;
        cnt_n   = '0;
      end
    endcase
  end

endmodule
